// File: rtl/opb_reg_pkg.sv
// Shared definitions for OPB slave register cores: FSM states, word map,
// status bit positions and the byte-enable merge used on register writes.
package opb_reg_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACK  = 2'd1,
      HOLD = 2'd2
   } opb_state_e;

   localparam logic WORD_DATA   = 1'b0;
   localparam logic WORD_STATUS = 1'b1;

   localparam int STAT_PEND_BIT = 0;
   localparam int STAT_CNT_LSB  = 16;
   localparam int STAT_CNT_W    = 16;

   // be[3] guards bits 31:24, i.e. OPB byte lane 0 once the bus vectors are
   // assigned into little-endian numbering.
   function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [3:0]  be);
      logic [31:0] res;
      res = old_val;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/opb_register_ppc2simulink_if.sv
// OPB master/slave signal bundle, kept in the bus' big-endian bit order.
interface opb_register_ppc2simulink_if;

   logic [0:31] OPB_ABus;
   logic [0:3]  OPB_BE;
   logic [0:31] OPB_DBus;
   logic        OPB_RNW;
   logic        OPB_select;
   logic        OPB_seqAddr;

   logic [0:31] Sl_DBus;
   logic        Sl_xferAck;
   logic        Sl_errAck;
   logic        Sl_retry;
   logic        Sl_toutSup;

   modport master (
      output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
      input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
   );

   modport slave (
      input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
      output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
   );

endinterface

// File: rtl/opb_slave_ack_fsm.sv
// OPB slave decode and single-beat acknowledge FSM, shared by the
// PPC->fabric and fabric->PPC register cores.
//
// state | meaning
// IDLE  | waiting for a select that hits the window
// ACK   | Sl_xferAck high, latched write presented for commit
// HOLD  | waiting for select to drop so a lingering select is not re-acked
module opb_slave_ack_fsm
   import opb_reg_pkg::*;
#(
   parameter logic [31:0] C_BASEADDR = 32'h01087200,
   parameter logic [31:0] C_HIGHADDR = 32'h010872FF
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] abus,
   input  logic        select,
   input  logic        rnw,
   input  logic [3:0]  be,
   input  logic [31:0] dbus,
   input  logic [31:0] rd_word0,
   input  logic [31:0] rd_word1,
   output logic        xfer_ack,
   output logic [31:0] rd_dbus,
   output logic        wr_commit,
   output logic        wr_word,
   output logic [3:0]  wr_be,
   output logic [31:0] wr_data
);

   opb_state_e  state_q, state_d;
   logic        hit;
   logic        load;
   logic        rnw_q;
   logic        word_q;
   logic [3:0]  be_q;
   logic [31:0] data_q;
   logic [31:0] rd_dbus_q;

   assign hit = select && (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (hit) begin
               state_d = ACK;
               load    = 1'b1;
            end
         end
         ACK:     state_d = HOLD;
         HOLD:    if (!select) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         rnw_q     <= 1'b1;
         word_q    <= WORD_DATA;
         be_q      <= '0;
         data_q    <= '0;
         rd_dbus_q <= '0;
      end else begin
         state_q <= state_d;
         if (load) begin
            rnw_q  <= rnw;
            word_q <= abus[2];
            be_q   <= be;
            data_q <= dbus;
         end
         // Read data only lives for the ack cycle; everything else drives zero.
         rd_dbus_q <= (load && rnw) ? (abus[2] ? rd_word1 : rd_word0) : '0;
      end
   end

   assign xfer_ack  = (state_q == ACK);
   assign rd_dbus   = rd_dbus_q;
   assign wr_commit = (state_q == ACK) && !rnw_q;
   assign wr_word   = word_q;
   assign wr_be     = be_q;
   assign wr_data   = data_q;

endmodule

// File: rtl/opb_register_ppc2simulink.sv
// PPC->fabric control register on OPB: byte-enable aware data word with a
// commit strobe, plus a read-only status word (write count, pending flag).
module opb_register_ppc2simulink
   import opb_reg_pkg::*;
#(
   parameter logic [31:0] C_BASEADDR    = 32'h01087200,
   parameter logic [31:0] C_HIGHADDR    = 32'h010872FF,
   parameter int          C_OPB_AWIDTH  = 32,
   parameter int          C_OPB_DWIDTH  = 32,
   parameter string       C_FAMILY      = "virtex6",
   parameter logic [31:0] C_RESET_VALUE = 32'h00000000
)
(
   input  logic                        OPB_Clk,
   input  logic                        OPB_Rst_n,
   opb_register_ppc2simulink_if.slave  bus,
   output logic [31:0]                 user_data_out,
   output logic                        user_data_valid,
   input  logic                        user_ack
);

   logic                  xfer_ack;
   logic [31:0]           rd_dbus;
   logic                  wr_commit;
   logic                  wr_word;
   logic [3:0]            wr_be;
   logic [31:0]           wr_data;
   logic [31:0]           status_word;
   logic [STAT_CNT_W-1:0] wr_count;
   logic                  pending;
   logic                  data_commit;
   logic                  unused_cfg;

   // Width and family parameters are fixed at 32/informational; seqAddr has no meaning here.
   assign unused_cfg = (C_OPB_AWIDTH == 32) ^ (C_OPB_DWIDTH == 32) ^
                       (C_FAMILY == "virtex6") ^ bus.OPB_seqAddr;

   opb_slave_ack_fsm #(
      .C_BASEADDR (C_BASEADDR),
      .C_HIGHADDR (C_HIGHADDR)
   ) u_ack_fsm (
      .clk       (OPB_Clk),
      .rst_n     (OPB_Rst_n),
      .abus      (bus.OPB_ABus),
      .select    (bus.OPB_select),
      .rnw       (bus.OPB_RNW),
      .be        (bus.OPB_BE),
      .dbus      (bus.OPB_DBus),
      .rd_word0  (user_data_out),
      .rd_word1  (status_word),
      .xfer_ack  (xfer_ack),
      .rd_dbus   (rd_dbus),
      .wr_commit (wr_commit),
      .wr_word   (wr_word),
      .wr_be     (wr_be),
      .wr_data   (wr_data)
   );

   always_comb begin
      status_word = '0;
      status_word[STAT_CNT_LSB +: STAT_CNT_W] = wr_count;
      status_word[STAT_PEND_BIT]              = pending;
   end

   assign data_commit = wr_commit && (wr_word == WORD_DATA);

   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n) begin
         user_data_out   <= C_RESET_VALUE;
         user_data_valid <= 1'b0;
         wr_count        <= '0;
         pending         <= 1'b0;
      end else begin
         user_data_valid <= data_commit;
         if (data_commit) begin
            user_data_out <= be_merge(user_data_out, wr_data, wr_be);
            wr_count      <= wr_count + 16'd1;
         end
         // A commit landing with user_ack leaves pending set: the new value is unseen.
         if (data_commit)   pending <= 1'b1;
         else if (user_ack) pending <= 1'b0;
      end
   end

   assign bus.Sl_DBus    = rd_dbus;
   assign bus.Sl_xferAck = xfer_ack;
   assign bus.Sl_errAck  = 1'b0;
   assign bus.Sl_retry   = 1'b0;
   assign bus.Sl_toutSup = 1'b0;

endmodule

// File: doc/opb_register_ppc2simulink.md
# opb_register_ppc2simulink

OPB slave register carrying control words from the PowerPC into user fabric: the write-direction counterpart of the simulink-to-PPC status registers on the same OPB bus. Each PPC write (byte-enable aware) updates a 32-bit user-facing register and raises a one-cycle commit strobe. A second word exposes a pending flag and a wrapping write counter so software can confirm that fabric consumed the value. Single clock domain: OPB_Clk drives both bus and user sides.

## Interface
- C_BASEADDR, 32'h01087200: first byte of the decoded window.
- C_HIGHADDR, 32'h010872FF: last byte of the decoded window.
- C_OPB_AWIDTH, 32: OPB address width; only 32 supported.
- C_OPB_DWIDTH, 32: OPB data width; only 32 supported.
- C_FAMILY, "virtex6": informational; no functional effect.
- C_RESET_VALUE, 32'h00000000: reset and power-up value of user_data_out.
- OPB_Clk  in  1  sole clock for all logic.
- OPB_Rst_n  in  1  reset, asynchronous assert, active-low.
- OPB_ABus  in  [0:31]  address, big-endian bit order.
- OPB_BE  in  [0:3]  byte enables; BE[0] covers DBus[0:7].
- OPB_DBus  in  [0:31]  write data.
- OPB_RNW  in  1  1 = read, 0 = write.
- OPB_select  in  1  master transfer request.
- OPB_seqAddr  in  1  ignored.
- Sl_DBus  out  [0:31]  read data; all zero outside the ack cycle.
- Sl_xferAck  out  1  one-cycle transfer acknowledge.
- Sl_errAck, Sl_retry, Sl_toutSup  out  1 each  tied 0.
- user_data_out  out  [31:0]  committed register value; user bit 31 = OPB bit 0.
- user_data_valid  out  1  one-cycle pulse on each commit to word 0.
- user_ack  in  1  fabric consumed value; clears pending.

## Operation
- Hit = OPB_select && C_BASEADDR <= OPB_ABus <= C_HIGHADDR. Word select = OPB_ABus[29]; bits [30:31] and all bits above 29 within the window ignored, so the two words alias through the window.
- Word 0 (offset 0x0): R/W data. Read returns user_data_out. Write merges OPB_DBus into user_data_out per byte enable; disabled bytes keep their old value. A write with BE = 0000 still commits and still pulses user_data_valid.
- Word 1 (offset 0x4): read-only status. Bits [31:16] = write count, 16-bit, wraps 0xFFFF -> 0x0000. Bit 0 = pending. Other bits read 0. Writes are acked and have no effect.
- Every word-0 write increments the count and sets pending. user_ack clears pending. When a commit and user_ack coincide, pending ends at 1 (the write wins).
- FSM states:
  - IDLE -> ACK on hit. At that edge, latch RNW, word select, BE and DBus; load Sl_DBus with read data when RNW = 1.
  - ACK -> HOLD unconditionally. Sl_xferAck is 1 only in ACK.
  - HOLD -> IDLE when OPB_select = 0; otherwise stay. This prevents a second ack for a select that lingers.
- No bursts: each transfer needs select to drop before the next is accepted.

## Timing
- Select and hit sampled at edge k -> Sl_xferAck and Sl_DBus valid during cycle k+1.
- Write commit at edge k+2: user_data_out, count and pending update at that edge, and user_data_valid is high during cycle k+2 only.
- Minimum spacing between accepted transfers: 3 cycles (IDLE, ACK, HOLD).
- Reset (async, any state, including mid-transfer): state IDLE; Sl_xferAck 0; Sl_DBus 0; user_data_out = C_RESET_VALUE; user_data_valid 0; count 0; pending 0. A write whose ACK was cut by reset is not committed.
- No outputs are combinational from inputs; all are registered.

## Structure
- Shared package opb_reg_pkg:
  - state enum {IDLE, ACK, HOLD};
  - word offsets;
  - status bit positions;
  - a function for BE-merged 32-bit byte writes, reused by other OPB register cores.
- One natural sub-module, opb_slave_ack_fsm: address decode, the three-state FSM and ack generation. It is shareable with the read-direction register.
- Top level holds the data register, status register and counter.

## Test plan
- Reset release, read 0x01087200 -> Sl_DBus 0x00000000 in the ack cycle; Sl_DBus 0 in all other cycles.
- Write 0xDEADBEEF to 0x01087200 with BE 1111 -> ack at k+1; user_data_out 0xDEADBEEF and one-cycle valid at k+2; status reads 0x00010001.
- Then write 0x11223344 with BE 0101 -> user_data_out 0xDE22BE44.
- Hold select high for 6 cycles -> exactly one Sl_xferAck.
- Commit and user_ack in the same cycle -> pending 1; a later lone user_ack -> pending 0. 65536 writes -> count wraps to 0x0000.
- Assert OPB_Rst_n low in the ACK cycle of a write of 0x12345678 -> ack drops immediately; user_data_out stays C_RESET_VALUE; no valid pulse. Access to 0x01087300 (outside the window) -> never acked.
